// File: rtl/data_memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter_pkg
// Description : Shared types and encodings for the data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic c_PORT_A = 1'b0;
    localparam logic c_PORT_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/data_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter_if
// Description : Requester ports A/B plus memory-side bus of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_arbiter_if #(
    parameter int N_BIT = 31
) ();
    logic             in_req_a;
    logic             in_we_a;
    logic [N_BIT:0]   in_addr_a;
    logic [N_BIT:0]   in_write_data_a;
    logic             out_ack_a;
    logic             out_err_a;
    logic [N_BIT:0]   out_read_data_a;

    logic             in_req_b;
    logic             in_we_b;
    logic [N_BIT:0]   in_addr_b;
    logic [N_BIT:0]   in_write_data_b;
    logic             out_ack_b;
    logic             out_err_b;
    logic [N_BIT:0]   out_read_data_b;

    logic             out_mem_we;
    logic [N_BIT:0]   out_mem_addr;
    logic [N_BIT:0]   out_mem_write_data;
    logic [N_BIT:0]   in_mem_read_data;
    logic             out_busy;

    modport slave (
        input  in_req_a, in_we_a, in_addr_a, in_write_data_a,
        output out_ack_a, out_err_a, out_read_data_a,
        input  in_req_b, in_we_b, in_addr_b, in_write_data_b,
        output out_ack_b, out_err_b, out_read_data_b,
        output out_mem_we, out_mem_addr, out_mem_write_data,
        input  in_mem_read_data,
        output out_busy
    );

    modport master (
        output in_req_a, in_we_a, in_addr_a, in_write_data_a,
        input  out_ack_a, out_err_a, out_read_data_a,
        output in_req_b, in_we_b, in_addr_b, in_write_data_b,
        input  out_ack_b, out_err_b, out_read_data_b,
        input  out_mem_we, out_mem_addr, out_mem_write_data,
        output in_mem_read_data,
        input  out_busy
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_arbiter_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way combinational round-robin grant selector.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import data_memory_arbiter_pkg::*;
(
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant_id
);
    always_comb begin
        o_grant_valid = i_req_a | i_req_b;
        o_grant_id    = c_PORT_A;
        // On a tie the port that did not win last time goes first.
        if (i_req_a && i_req_b) begin
            o_grant_id = (i_last_grant == c_PORT_A) ? c_PORT_B : c_PORT_A;
        end else if (i_req_b) begin
            o_grant_id = c_PORT_B;
        end
    end
endmodule
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Round-robin arbiter sharing one single-port data memory
//               between a CPU port (A) and a loader/debug port (B).
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int N_BIT    = 31,
    parameter int MEM_SIZE = 2047
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    data_memory_arbiter_if.slave bus
);
    localparam logic [N_BIT:0] c_MEM_LAST = (N_BIT+1)'(MEM_SIZE);

    state_t         r_state;
    state_t         w_next_state;
    logic           r_last_grant;
    logic           r_owner;
    logic           r_we;
    logic           r_in_range;
    logic [N_BIT:0] r_addr;
    logic [N_BIT:0] r_wdata;
    logic [N_BIT:0] r_rd_a;
    logic [N_BIT:0] r_rd_b;

    logic           w_grant_valid;
    logic           w_grant_id;
    logic           w_sel_we;
    logic [N_BIT:0] w_sel_addr;
    logic [N_BIT:0] w_sel_wdata;

    logic           w_mem_we;
    logic [N_BIT:0] w_mem_addr;
    logic [N_BIT:0] w_mem_wdata;
    logic           w_ack_a;
    logic           w_ack_b;
    logic           w_err_a;
    logic           w_err_b;
    logic           w_busy;

    rr_arbiter_2 u_rr_arbiter (
        .i_req_a       (bus.in_req_a),
        .i_req_b       (bus.in_req_b),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    always_comb begin
        w_sel_we    = bus.in_we_a;
        w_sel_addr  = bus.in_addr_a;
        w_sel_wdata = bus.in_write_data_a;
        if (w_grant_id == c_PORT_B) begin
            w_sel_we    = bus.in_we_b;
            w_sel_addr  = bus.in_addr_b;
            w_sel_wdata = bus.in_write_data_b;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Memory strobes decode straight from state so reset kills a write at once.
    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_ack_a      = 1'b0;
        w_ack_b      = 1'b0;
        w_err_a      = 1'b0;
        w_err_b      = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next_state = ST_RESP;
                w_busy       = 1'b1;
                w_mem_we     = r_we & r_in_range;
                w_mem_addr   = r_addr;
                w_mem_wdata  = r_wdata;
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
                w_busy       = 1'b1;
                if (r_owner == c_PORT_A) begin
                    w_ack_a = 1'b1;
                    w_err_a = ~r_in_range;
                end else begin
                    w_ack_b = 1'b1;
                    w_err_b = ~r_in_range;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_last_grant <= c_PORT_B;
            r_owner      <= c_PORT_A;
            r_we         <= 1'b0;
            r_in_range   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd_a       <= '0;
            r_rd_b       <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_grant_valid) begin
                r_owner    <= w_grant_id;
                r_we       <= w_sel_we;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                r_in_range <= (w_sel_addr <= c_MEM_LAST);
            end
            if ((r_state == ST_ACCESS) && !r_we) begin
                if (r_owner == c_PORT_A) begin
                    r_rd_a <= r_in_range ? bus.in_mem_read_data : '0;
                end else begin
                    r_rd_b <= r_in_range ? bus.in_mem_read_data : '0;
                end
            end
            if (r_state == ST_RESP) begin
                r_last_grant <= r_owner;
            end
        end
    end

    assign bus.out_mem_we         = w_mem_we;
    assign bus.out_mem_addr       = w_mem_addr;
    assign bus.out_mem_write_data = w_mem_wdata;
    assign bus.out_ack_a          = w_ack_a;
    assign bus.out_ack_b          = w_ack_b;
    assign bus.out_err_a          = w_err_a;
    assign bus.out_err_b          = w_err_b;
    assign bus.out_read_data_a    = r_rd_a;
    assign bus.out_read_data_b    = r_rd_b;
    assign bus.out_busy           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_arbiter
// Description : Self-checking bench: directed scenarios plus random traffic
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;
    localparam int N_BIT    = 31;
    localparam int MEM_SIZE = 2047;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clear = 1'b1;
    always #5 clk = ~clk;

    data_memory_arbiter_if #(.N_BIT(N_BIT)) bus ();

    data_memory_arbiter #(.N_BIT(N_BIT), .MEM_SIZE(MEM_SIZE)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    // Behavioural single-port memory with combinational read.
    logic [31:0] mem [0:MEM_SIZE];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i <= MEM_SIZE; i++) mem[i] <= '0;
        end else if (bus.out_mem_we) begin
            mem[bus.out_mem_addr[10:0]] <= bus.out_mem_write_data;
        end
    end
    assign bus.in_mem_read_data = (bus.out_mem_addr <= 32'(MEM_SIZE)) ?
                                  mem[bus.out_mem_addr[10:0]] : 32'd0;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: transaction phase counter and expected results.
    logic [31:0] ref_mem [0:MEM_SIZE];
    int          m_stage;    // cycles into current transaction: 0 none, 1 access, 2 ack
    int          m_owner;
    int          m_last;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic        m_inr;
    logic [31:0] exp_rd [2];

    // Requester agents.
    logic        p_req  [2];
    logic        p_we   [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd   [2];
    txn_t        q_a [$];
    txn_t        q_b [$];
    bit          rnd_on;
    bit          scramble_en;

    int          ack_port [$];
    int          ack_cyc  [$];
    int          we_cnt;
    bit          seen_err_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_stage   = 0;
        m_owner   = 0;
        m_last    = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic model_edge();
        int g;
        case (m_stage)
            0: begin
                g = -1;
                if (p_req[0] && p_req[1]) g = (m_last == 0) ? 1 : 0;
                else if (p_req[0])        g = 0;
                else if (p_req[1])        g = 1;
                if (g >= 0) begin
                    m_owner = g;
                    m_we    = p_we[g];
                    m_addr  = p_addr[g];
                    m_wd    = p_wd[g];
                    m_inr   = (p_addr[g] <= 32'(MEM_SIZE));
                    m_stage = 1;
                end
            end
            1: begin
                if (m_inr && m_we) ref_mem[m_addr[10:0]] = m_wd;
                if (!m_we) exp_rd[m_owner] = m_inr ? ref_mem[m_addr[10:0]] : 32'd0;
                m_stage = 2;
            end
            default: begin
                m_last  = m_owner;
                m_stage = 0;
            end
        endcase
    endtask

    task automatic check_all();
        logic ea, eb;
        ea = (m_stage == 2) && (m_owner == 0);
        eb = (m_stage == 2) && (m_owner == 1);
        check("busy",     bus.out_busy, m_stage != 0);
        check("mem_we",   bus.out_mem_we, (m_stage == 1) && m_we && m_inr);
        check("mem_addr", bus.out_mem_addr, (m_stage == 1) ? m_addr : 32'd0);
        check("mem_wd",   bus.out_mem_write_data, (m_stage == 1) ? m_wd : 32'd0);
        check("ack_a",    bus.out_ack_a, ea);
        check("ack_b",    bus.out_ack_b, eb);
        check("err_a",    bus.out_err_a, ea && !m_inr);
        check("err_b",    bus.out_err_b, eb && !m_inr);
        check("rd_a",     bus.out_read_data_a, exp_rd[0]);
        check("rd_b",     bus.out_read_data_b, exp_rd[1]);
        if (bus.out_ack_a === 1'b1) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
        if (bus.out_ack_b === 1'b1) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
        if (bus.out_mem_we === 1'b1) we_cnt++;
        if (bus.out_err_b === 1'b1) seen_err_b = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 32'd2047;
            1:       return 32'd2048;
            2:       return $urandom;
            default: return 32'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic drive();
        bus.in_req_a        = p_req[0];
        bus.in_we_a         = p_we[0];
        bus.in_addr_a       = p_addr[0];
        bus.in_write_data_a = p_wd[0];
        bus.in_req_b        = p_req[1];
        bus.in_we_b         = p_we[1];
        bus.in_addr_b       = p_addr[1];
        bus.in_write_data_b = p_wd[1];
    endtask

    task automatic load_ports();
        txn_t t;
        for (int p = 0; p < 2; p++) begin
            if (!p_req[p]) begin
                if ((p == 0 && q_a.size() > 0) || (p == 1 && q_b.size() > 0)) begin
                    t = (p == 0) ? q_a.pop_front() : q_b.pop_front();
                    p_req[p] = 1'b1; p_we[p] = t.we; p_addr[p] = t.addr; p_wd[p] = t.wd;
                end else if (rnd_on && $urandom_range(0, 2) == 0) begin
                    p_req[p]  = 1'b1;
                    p_we[p]   = 1'($urandom_range(0, 1));
                    p_addr[p] = rand_addr();
                    p_wd[p]   = $urandom;
                end
            end
        end
        drive();
    endtask

    task automatic update_drivers();
        for (int p = 0; p < 2; p++) begin
            if (m_stage == 2 && m_owner == p) p_req[p] = 1'b0;
            if (scramble_en && m_stage == 1 && m_owner == p) begin
                p_we[p]   = 1'($urandom_range(0, 1));
                p_addr[p] = $urandom;
                p_wd[p]   = $urandom;
            end
        end
        load_ports();
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
        update_drivers();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!(q_a.size() == 0 && q_b.size() == 0 && !p_req[0] && !p_req[1] && m_stage == 0)) begin
            if (n >= budget) begin
                n_chk++; n_err++;
                $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic push(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        txn_t t;
        t.we = we; t.addr = addr; t.wd = wd;
        if (p == 0) q_a.push_back(t); else q_b.push_back(t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i <= MEM_SIZE; i++) ref_mem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wd[p] = '0;
        end
        rnd_on = 1'b0; scramble_en = 1'b1; we_cnt = 0; seen_err_b = 1'b0;
        model_reset();
        drive();

        // Reset state, then idle with no requests.
        repeat (2) begin @(negedge clk); check_all(); end
        mem_clear = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();

        // Single-port write then read.
        we_cnt = 0; ack_port.delete(); ack_cyc.delete();
        push(0, 1'b1, 32'd123, 32'hAAAA);
        push(0, 1'b0, 32'd123, 32'h0);
        load_ports();
        run_until_idle(20);
        check("t2_rd_a", bus.out_read_data_a, 32'hAAAA);
        check("t2_we_cycles", 32'(we_cnt), 32'd1);
        check("t2_acks", 32'(ack_port.size()), 32'd2);

        // Contention straight after reset: A wins the tie.
        do_reset();
        ack_port.delete(); ack_cyc.delete();
        push(0, 1'b1, 32'd2000, 32'd322228);
        push(1, 1'b0, 32'd2000, 32'h0);
        load_ports();
        run_until_idle(20);
        check("t3_acks", 32'(ack_port.size()), 32'd2);
        if (ack_port.size() == 2) begin
            check("t3_first", 32'(ack_port[0]), 32'd0);
            check("t3_second", 32'(ack_port[1]), 32'd1);
            check("t3_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
        end
        check("t3_rd_b", bus.out_read_data_b, 32'd322228);

        // Fairness under continuous requests from both ports.
        ack_port.delete(); ack_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            push(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
            push(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
        end
        load_ports();
        run_until_idle(40);
        check("t4_acks", 32'(ack_port.size()), 32'd6);
        for (int i = 0; i < ack_port.size() && i < 6; i++) begin
            check("t4_order", 32'(ack_port[i]), 32'(i % 2));
            if (i > 0) check("t4_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end

        // Out-of-range write must not disturb memory.
        seen_err_b = 1'b0;
        push(0, 1'b1, 32'd2047, 32'hCAFE);
        load_ports();
        run_until_idle(20);
        we_cnt = 0;
        push(1, 1'b1, 32'd2048, 32'h1234);
        load_ports();
        run_until_idle(20);
        check("t5_err_b", 32'(seen_err_b), 32'd1);
        check("t5_no_we", 32'(we_cnt), 32'd0);
        push(0, 1'b0, 32'd2047, 32'h0);
        load_ports();
        run_until_idle(20);
        check("t5_rd_a", bus.out_read_data_a, 32'hCAFE);

        // Reset in the middle of an A write.
        scramble_en = 1'b0;
        push(0, 1'b1, 32'd500, 32'h5555);
        load_ports();
        for (int n = 0; n < 10 && m_stage != 1; n++) step();
        check("t6_in_access", 32'(m_stage), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_we_drop", bus.out_mem_we, 1'b0);
        check("t6_busy_drop", bus.out_busy, 1'b0);
        model_reset();
        ack_port.delete(); ack_cyc.delete();
        repeat (2) step();
        check("t6_no_ack", 32'(ack_port.size()), 32'd0);
        rst_n = 1'b1;
        run_until_idle(20);
        check("t6_acks", 32'(ack_port.size()), 32'd1);
        if (ack_port.size() > 0) check("t6_port", 32'(ack_port[0]), 32'd0);
        push(0, 1'b0, 32'd500, 32'h0);
        load_ports();
        run_until_idle(20);
        check("t6_rd_a", bus.out_read_data_a, 32'h5555);
        scramble_en = 1'b1;

        // Random traffic from both ports.
        rnd_on = 1'b1;
        repeat (400) step();
        rnd_on = 1'b0;
        run_until_idle(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data_memory_mips instance between two requesters.
  - Port A: CPU load/store stage.
  - Port B: loader/debug port.
- Registered req/ack handshake per port; round-robin on contention.
- Word-address range check against the memory size; one memory access in flight at a time.

Parameters:
N_BIT, 31, MSB index of address/data buses (width N_BIT+1)
MEM_SIZE, 2047, last valid word address; addr > MEM_SIZE is out of range

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_req_a  input  1  port A request; held high until ack
in_we_a  input  1  port A write (1) / read (0)
in_addr_a  input  N_BIT+1  port A word address
in_write_data_a  input  N_BIT+1  port A write data
out_ack_a  output  1  one-cycle completion pulse, port A
out_err_a  output  1  valid with out_ack_a; address out of range
out_read_data_a  output  N_BIT+1  port A read data; updated on port A ack, held otherwise
in_req_b, in_we_b, in_addr_b, in_write_data_b, out_ack_b, out_err_b, out_read_data_b  same as port A, for port B
out_mem_we  output  1  to memory in_we
out_mem_addr  output  N_BIT+1  to memory in_addr
out_mem_write_data  output  N_BIT+1  to memory in_write_data
in_mem_read_data  input  N_BIT+1  from memory out_read_data (combinational read)
out_busy  output  1  high in ACCESS and RESP

Behaviour:
- Reset (async, in_rst_n=0):
  - State IDLE; all outputs 0; read-data registers 0.
  - last_grant = B, so A wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample the req inputs at the rising edge.
  - If exactly one req is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - On a grant, latch the granted port's we/addr/write_data into internal regs, set the owner, and go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (one cycle):
  - out_mem_addr and out_mem_write_data come from the latch.
  - out_mem_we = latched we AND in-range.
  - The memory write commits at the edge ending ACCESS.
  - At that edge, capture in_mem_read_data (reads only) into the owner's read-data register; capture 0 if out of range.
  - Then go to RESP.
- RESP (one cycle):
  - out_ack_<owner> = 1.
  - out_err_<owner> = 1 if out of range.
  - last_grant <= owner; go to IDLE.
- Outside ACCESS: out_mem_we = 0, out_mem_addr = 0, out_mem_write_data = 0.
- Latency and throughput:
  - Ack is asserted 2 cycles after the IDLE edge that samples req.
  - Maximum throughput is one transaction per 3 cycles.
- Requester rules:
  - A requester drops req at the edge ending its ack cycle.
  - req still high in the following IDLE is a new transaction.
  - Changing addr/data/we while waiting is ignored after the latch.
- Writes return out_read_data unchanged (register not updated); out_ack only.
- Range check:
  - Unsigned compare addr > MEM_SIZE.
  - No memory write occurs; out_err=1; read data 0.
- Fairness:
  - Under continuous requests from both ports, grants alternate A, B, A, B.
  - A port that requests alone is granted regardless of last_grant.
- Reset mid-operation:
  - out_mem_we falls immediately (state decode).
  - No ack is issued; the pending transaction is dropped.
  - A write is not guaranteed to have committed.
- The non-owner's ack, err and read data stay unchanged throughout.

Decomposition:
- Shared include data_memory_arbiter_defs.vh: state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), port IDs (PORT_A=1'b0, PORT_B=1'b1).
- One sub-module: rr_arbiter_2.
  - Combinational.
  - Inputs: req_a, req_b, last_grant.
  - Outputs: grant_valid, grant_id.
- FSM, latches and range check live in the top.

Test Plan:
1. Reset check: in_rst_n=0 for 2 cycles -> all outputs 0, out_busy=0; release -> stays IDLE with no reqs.
2. Single-port write then read:
   - A writes 32'hAAAA to 123.
   - Then A reads 123 -> out_mem_we=1 for exactly one cycle in the first transaction.
   - Second transaction: out_ack_a 2 cycles after sample, out_read_data_a=32'hAAAA.
3. Contention:
   - Simultaneous A write 2000 <- 32'd322228 and B read 2000 -> A granted first (tie after reset).
   - B then returns 32'd322228; ack order A then B, 3 cycles apart.
4. Fairness: both reqs held continuously for 6 transactions -> grant sequence A,B,A,B,A,B; never the same port twice in a row.
5. Out of range:
   - B writes 32'h1234 to 2048 -> out_err_b=1 with ack, out_mem_we stays 0.
   - Then read of 2047 by A returns prior contents, unchanged.
6. Reset mid-ACCESS during an A write -> out_mem_we drops asynchronously, no out_ack_a.
   - After release, req_a still high -> a new, complete transaction with correct ack.
